// File: rtl/psram_arbiter.sv
// Round-robin arbiter sharing one PSRAM line controller between two line masters.
// Serialises read/write line requests and steers the controller's line-buffer handshake.
module psram_arbiter #(
  parameter int unsigned LAW          = 18,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic           mem_clk,
  input  logic           reset,

  input  logic           req0_rd,
  input  logic           req0_wr,
  input  logic [LAW-1:0] req0_addr,
  input  logic [127:0]   req0_wdata,
  output logic           req0_done,
  output logic           req0_en,
  output logic           req0_we,
  output logic [1:0]     req0_caddr,

  input  logic           req1_rd,
  input  logic           req1_wr,
  input  logic [LAW-1:0] req1_addr,
  input  logic [127:0]   req1_wdata,
  output logic           req1_done,
  output logic           req1_en,
  output logic           req1_we,
  output logic [1:0]     req1_caddr,

  output logic [127:0]   m_rdata,

  output logic           mem_rd,
  output logic           mem_wr,
  output logic [LAW-1:0] raddr,
  output logic [LAW-1:0] waddr,
  input  logic           rd_busy,
  input  logic           wr_busy,
  input  logic           cache_en,
  input  logic           cache_we,
  input  logic [1:0]     cache_addr,
  input  logic [127:0]   cache_wdata,
  output logic [127:0]   cache_rdata,

  output logic [1:0]     grant,
  output logic           timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ACCEPT,
    S_BUSY,
    S_DONE
  } state_t;

  localparam int unsigned TW = $clog2(BUSY_TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [1:0]     grant_q, grant_d;
  logic           last_q, last_d;
  logic           op_wr_q, op_wr_d;
  logic           mem_rd_q, mem_rd_d;
  logic           mem_wr_q, mem_wr_d;
  logic [1:0]     done_q, done_d;
  logic           terr_q, terr_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [LAW-1:0] raddr_q, raddr_d;
  logic [LAW-1:0] waddr_q, waddr_d;

  logic           pend0, pend1, sel1, sel_wr, busy_match;
  logic [LAW-1:0] sel_addr;

  always_comb begin
    pend0      = req0_rd | req0_wr;
    pend1      = req1_rd | req1_wr;
    // last_q=1 means port 1 was served last, so a tie goes to port 0
    sel1       = pend1 & (~pend0 | ~last_q);
    sel_wr     = sel1 ? req1_wr : req0_wr;
    sel_addr   = sel1 ? req1_addr : req0_addr;
    busy_match = op_wr_q ? wr_busy : rd_busy;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    op_wr_d  = op_wr_q;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    done_d   = '0;
    terr_d   = terr_q;
    timer_d  = timer_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (!(rd_busy | wr_busy) && (pend0 | pend1)) begin
          grant_d  = sel1 ? 2'b10 : 2'b01;
          op_wr_d  = sel_wr;
          raddr_d  = sel_addr;
          waddr_d  = sel_addr;
          mem_wr_d = sel_wr;
          mem_rd_d = ~sel_wr;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_ACCEPT;
      end
      S_ACCEPT: begin
        if (busy_match) begin
          state_d = S_BUSY;
        end else if (timer_q == TIMER_LAST) begin
          terr_d  = 1'b1;
          done_d  = grant_q;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (!busy_match) begin
          done_d  = grant_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = grant_q[1];
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      last_q   <= 1'b1;
      op_wr_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      done_q   <= '0;
      terr_q   <= 1'b0;
      timer_q  <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      op_wr_q  <= op_wr_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
      timer_q  <= timer_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
    end
  end

  logic in_busy;
  assign in_busy = (state_q == S_BUSY);

  assign req0_en     = in_busy & grant_q[0] & cache_en;
  assign req0_we     = in_busy & grant_q[0] & cache_we;
  assign req1_en     = in_busy & grant_q[1] & cache_en;
  assign req1_we     = in_busy & grant_q[1] & cache_we;
  assign req0_caddr  = cache_addr;
  assign req1_caddr  = cache_addr;
  assign m_rdata     = cache_wdata;
  assign cache_rdata = grant_q[1] ? req1_wdata : req0_wdata;

  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign raddr       = raddr_q;
  assign waddr       = waddr_q;
  assign grant       = grant_q;
  assign timeout_err = terr_q;

endmodule
